// File: rtl/frame_arbiter_pkg.sv
// Shared definitions for the frame arbiter: FSM encodings and the default pixel width.
package frame_arbiter_pkg;

  localparam int DEFAULT_FIFO_DWIDTH = 24;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BURST0 = 2'd1;
  localparam logic [1:0] ST_BURST1 = 2'd2;

endpackage

// File: rtl/frame_arbiter_counter.sv
// Pixel-in-frame counter: advances per transfer, clears on the last pixel of a frame.
module frame_counter #(
  parameter int FRAME_PIXELS = 4,
  parameter int CW           = $clog2(FRAME_PIXELS + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clear,
  output logic o_tc
);

  localparam logic [CW-1:0] TC_VAL = CW'(FRAME_PIXELS - 1);

  logic [CW-1:0] r_count;

  // Clear wins over inc so the terminal transfer wraps straight to zero.
  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/frame_arbiter.sv
// Grants whole frames from one of two pixel FIFOs to a single downstream FIFO.
// Handshake: a pixel moves when the granted source is non-empty and the output is not full; the write lands one cycle later.
module frame_arbiter
  import frame_arbiter_pkg::*;
#(
  parameter int FIFO_DWIDTH  = DEFAULT_FIFO_DWIDTH,
  parameter int FRAME_PIXELS = 720 * 540
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   fifo_in0_rd_en,
  input  logic [FIFO_DWIDTH-1:0] fifo_in0_dout,
  input  logic                   fifo_in0_empty,
  output logic                   fifo_in1_rd_en,
  input  logic [FIFO_DWIDTH-1:0] fifo_in1_dout,
  input  logic                   fifo_in1_empty,
  output logic                   fifo_out_wr_en,
  output logic [FIFO_DWIDTH-1:0] fifo_out_din,
  input  logic                   fifo_out_full,
  output logic                   fifo_out_src,
  output logic                   frame_done,
  output logic [1:0]             o_dbg_state
);

  logic [1:0]             r_state;
  logic [1:0]             w_next_state;
  logic                   r_last_grant;
  logic                   w_xfer0;
  logic                   w_xfer1;
  logic                   w_xfer;
  logic                   w_tc;
  logic                   w_last;
  logic                   r_wr_en;
  logic [FIFO_DWIDTH-1:0] r_din;
  logic                   r_src;
  logic                   r_frame_done;

  assign w_xfer0 = (r_state == ST_BURST0) && !fifo_in0_empty && !fifo_out_full;
  assign w_xfer1 = (r_state == ST_BURST1) && !fifo_in1_empty && !fifo_out_full;
  assign w_xfer  = w_xfer0 || w_xfer1;
  assign w_last  = w_xfer && w_tc;

  frame_counter #(
    .FRAME_PIXELS (FRAME_PIXELS)
  ) u_frame_counter (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_xfer),
    .i_clear (w_last),
    .o_tc    (w_tc)
  );

  // On a tie the source that did not own the previous frame wins.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!fifo_in0_empty && !fifo_in1_empty) begin
          w_next_state = r_last_grant ? ST_BURST0 : ST_BURST1;
        end else if (!fifo_in0_empty) begin
          w_next_state = ST_BURST0;
        end else if (!fifo_in1_empty) begin
          w_next_state = ST_BURST1;
        end
      end
      ST_BURST0, ST_BURST1: begin
        if (w_last) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (w_last) begin
        r_last_grant <= w_xfer1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_en      <= 1'b0;
      r_din        <= '0;
      r_src        <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_wr_en      <= w_xfer;
      r_frame_done <= w_last;
      if (w_xfer) begin
        r_din <= w_xfer1 ? fifo_in1_dout : fifo_in0_dout;
        r_src <= w_xfer1;
      end
    end
  end

  assign fifo_in0_rd_en = w_xfer0;
  assign fifo_in1_rd_en = w_xfer1;
  assign fifo_out_wr_en = r_wr_en;
  assign fifo_out_din   = r_din;
  assign fifo_out_src   = r_src;
  assign frame_done     = r_frame_done;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_frame_arbiter.sv
// Directed bench for frame_arbiter with FIFO models and an expected-write scoreboard.
module tb_frame_arbiter;

  localparam int W  = 24;
  localparam int FP = 4;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST1 = 2'd2;

  logic         clock;
  logic         reset;
  logic         fifo_in0_rd_en;
  logic [W-1:0] fifo_in0_dout;
  logic         fifo_in0_empty;
  logic         fifo_in1_rd_en;
  logic [W-1:0] fifo_in1_dout;
  logic         fifo_in1_empty;
  logic         fifo_out_wr_en;
  logic [W-1:0] fifo_out_din;
  logic         fifo_out_full;
  logic         fifo_out_src;
  logic         frame_done;
  logic [1:0]   dbg_state;

  frame_arbiter #(
    .FIFO_DWIDTH  (W),
    .FRAME_PIXELS (FP)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .fifo_in0_rd_en (fifo_in0_rd_en),
    .fifo_in0_dout  (fifo_in0_dout),
    .fifo_in0_empty (fifo_in0_empty),
    .fifo_in1_rd_en (fifo_in1_rd_en),
    .fifo_in1_dout  (fifo_in1_dout),
    .fifo_in1_empty (fifo_in1_empty),
    .fifo_out_wr_en (fifo_out_wr_en),
    .fifo_out_din   (fifo_out_din),
    .fifo_out_full  (fifo_out_full),
    .fifo_out_src   (fifo_out_src),
    .frame_done     (frame_done),
    .o_dbg_state    (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // FIFO models, scoreboard and bookkeeping
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W:0]   exp_q[$];
  logic         frame_srcs[$];
  int n_vec = 0;
  int n_fail = 0;
  int n_reads0 = 0;
  int n_reads1 = 0;
  int pix_cnt = 0;
  logic cur_src = 1'b0;
  logic prev_done = 1'b0;
  int cyc = 0;
  int frame_start = 0;
  int frame_len = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifos();
    fifo_in0_empty = (q0.size() == 0);
    fifo_in1_empty = (q1.size() == 0);
    fifo_in0_dout  = (q0.size() != 0) ? q0[0] : '0;
    fifo_in1_dout  = (q1.size() != 0) ? q1[0] : '0;
  endtask

  // One clock: check read legality, advance FIFOs, compare DUT writes to the scoreboard.
  task automatic tick();
    logic rd0, rd1, rst_s, exp_done;
    logic [W:0] e;
    #1;
    rd0   = fifo_in0_rd_en;
    rd1   = fifo_in1_rd_en;
    rst_s = reset;
    if (rd0 && rd1) chk("rd_both", 32'(rd0 & rd1), 32'd0);
    if (rd0) chk("rd0_legal", 32'((q0.size() == 0) || fifo_out_full), 32'd0);
    if (rd1) chk("rd1_legal", 32'((q1.size() == 0) || fifo_out_full), 32'd0);
    if (!rst_s && rd0 && q0.size() != 0) exp_q.push_back({1'b0, q0[0]});
    if (!rst_s && rd1 && q1.size() != 0) exp_q.push_back({1'b1, q1[0]});
    @(posedge clock);
    #1;
    cyc++;
    if (rd0 && q0.size() != 0) begin void'(q0.pop_front()); n_reads0++; end
    if (rd1 && q1.size() != 0) begin void'(q1.pop_front()); n_reads1++; end
    if (rst_s) begin
      exp_q.delete();
      pix_cnt   = 0;
      prev_done = 1'b0;
      chk("rst_wr_en", 32'(fifo_out_wr_en), 32'd0);
      chk("rst_din", 32'(fifo_out_din), 32'd0);
      chk("rst_src", 32'(fifo_out_src), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_rd0", 32'(fifo_in0_rd_en), 32'd0);
      chk("rst_rd1", 32'(fifo_in1_rd_en), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    end else begin
      if (prev_done) chk("gap_after_done", 32'(fifo_out_wr_en), 32'd0);
      exp_done = 1'b0;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_en", 32'(fifo_out_wr_en), 32'd1);
        chk("din", 32'(fifo_out_din), 32'(e[W-1:0]));
        chk("src", 32'(fifo_out_src), 32'(e[W]));
        if (pix_cnt == 0) begin
          cur_src     = e[W];
          frame_start = cyc;
        end else begin
          chk("mixed_frame", 32'(e[W]), 32'(cur_src));
        end
        pix_cnt++;
        if (pix_cnt == FP) begin
          exp_done  = 1'b1;
          frame_len = cyc - frame_start;
          frame_srcs.push_back(cur_src);
          pix_cnt = 0;
        end
        chk("frame_done", 32'(frame_done), 32'(exp_done));
        if (exp_done) chk("idle_after_last", 32'(dbg_state), 32'(S_IDLE));
      end else begin
        chk("no_wr", 32'(fifo_out_wr_en), 32'd0);
        chk("no_done", 32'(frame_done), 32'd0);
      end
      prev_done = exp_done;
    end
    drive_fifos();
  endtask

  task automatic fill(input int which, input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) begin
      if (which == 0) q0.push_back(base + W'(i));
      else            q1.push_back(base + W'(i));
    end
    drive_fifos();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_frames(input int target, input string tag);
    int budget;
    budget = 0;
    while (frame_srcs.size() < target && budget < 200) begin
      tick();
      budget++;
    end
    if (frame_srcs.size() < target) chk({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    int base_frames;
    int budget;
    reset         = 1'b1;
    fifo_out_full = 1'b0;
    drive_fifos();

    // Reset state
    do_reset();

    // Single source frame, consecutive writes
    fill(0, 4, 24'h102030);
    run_frames(1, "single");
    chk("single_src", 32'(frame_srcs[0]), 32'd0);
    chk("single_consec", 32'(frame_len), 32'(FP - 1));
    repeat (3) tick();

    // Both sources loaded: alternating whole frames starting with src 0
    do_reset();
    frame_srcs.delete();
    fill(0, 8, 24'hA00000);
    fill(1, 8, 24'hB00000);
    run_frames(4, "alt");
    for (int i = 0; i < 4; i++) chk("alt_order", 32'(frame_srcs[i]), 32'(i % 2));
    repeat (3) tick();

    // Output full held for 3 cycles after pixel 2
    do_reset();
    frame_srcs.delete();
    n_reads0 = 0;
    fill(0, 4, 24'hC00000);
    budget = 0;
    while (n_reads0 < 2 && budget < 50) begin tick(); budget++; end
    if (n_reads0 < 2) chk("full_pre_timeout", 32'd1, 32'd0);
    fifo_out_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("full_hold_rd0", 32'(fifo_in0_rd_en), 32'd0);
      chk("full_hold_wr", 32'(fifo_out_wr_en), 32'd0);
    end
    chk("full_hold_reads", 32'(n_reads0), 32'd2);
    fifo_out_full = 1'b0;
    run_frames(1, "full");
    chk("full_frame_src", 32'(frame_srcs[0]), 32'd0);
    chk("full_reads", 32'(n_reads0), 32'd4);
    repeat (3) tick();

    // FIFO 1 runs dry mid-frame while FIFO 0 is loaded
    do_reset();
    frame_srcs.delete();
    n_reads0 = 0;
    n_reads1 = 0;
    fill(1, 2, 24'hD00000);
    budget = 0;
    while (n_reads1 < 2 && budget < 50) begin tick(); budget++; end
    if (n_reads1 < 2) chk("dry_pre_timeout", 32'd1, 32'd0);
    fill(0, 4, 24'hE00000);
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      chk("dry_state", 32'(dbg_state), 32'(S_BURST1));
      chk("dry_rd0", 32'(fifo_in0_rd_en), 32'd0);
    end
    chk("dry_no_q0_reads", 32'(n_reads0), 32'd0);
    fill(1, 2, 24'hD00002);
    run_frames(2, "dry");
    chk("dry_first_src", 32'(frame_srcs[0]), 32'd1);
    chk("dry_second_src", 32'(frame_srcs[1]), 32'd0);
    repeat (3) tick();

    // Reset mid-frame, then the next tie goes to src 0
    frame_srcs.delete();
    fill(0, 4, 24'hF00000);
    run_frames(1, "pre_rst");
    repeat (2) tick();
    n_reads1 = 0;
    fill(0, 4, 24'hF10000);
    fill(1, 4, 24'hF20000);
    budget = 0;
    while (n_reads1 < 2 && budget < 50) begin tick(); budget++; end
    if (n_reads1 < 2) chk("midrst_pre_timeout", 32'd1, 32'd0);
    chk("midrst_partial_src", 32'(cur_src), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fill(1, 4, 24'hF30000);
    base_frames = frame_srcs.size();
    run_frames(base_frames + 1, "post_rst");
    chk("post_rst_tie_src", 32'(frame_srcs[base_frames]), 32'd0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_arbiter.md
FRAME_ARBITER -- requirements
Module: frame_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- FIFO_DWIDTH, 24, pixel width (RGB 8:8:8).
- FRAME_PIXELS, 720*540, pixels per frame; legal range 1 to 2^20.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clock, in, 1, sole clock; all state updates on rising edge.
- reset, in, 1, synchronous, active-high.
- fifo_in0_rd_en, out, 1, read strobe, input FIFO 0 (combinational).
- fifo_in0_dout, in, FIFO_DWIDTH, input FIFO 0 head pixel.
- fifo_in0_empty, in, 1, input FIFO 0 empty.
- fifo_in1_rd_en, out, 1, read strobe, input FIFO 1 (combinational).
- fifo_in1_dout, in, FIFO_DWIDTH, input FIFO 1 head pixel.
- fifo_in1_empty, in, 1, input FIFO 1 empty.
- fifo_out_wr_en, out, 1, registered write strobe into the grayscale input FIFO.
- fifo_out_din, out, FIFO_DWIDTH, registered pixel.
- fifo_out_full, in, 1, grayscale input FIFO full.
- fifo_out_src, out, 1, registered source id of fifo_out_din (0/1).
- frame_done, out, 1, registered one-cycle pulse on the last pixel of a frame.

Function
REQ-003 The block SHALL share one grayscale datapath between two pixel streams, granting whole frames, never interleaving pixels of different sources within a frame.
REQ-004 FSM states SHALL be IDLE, BURST0, BURST1.
REQ-005 IDLE: if exactly one input is non-empty, go to that source's BURST; if both are non-empty, grant the source not equal to last_grant; if neither is non-empty, stay in IDLE; no reads in IDLE.
REQ-006 In BURSTn, transfer condition = fifo_inN_empty==0 and fifo_out_full==0; when true, fifo_inN_rd_en=1 in the same cycle, and the other rd_en SHALL be 0 at all times.
REQ-007 A transfer SHALL produce fifo_out_wr_en=1 with fifo_out_din=fifo_inN_dout and fifo_out_src=N on the next cycle (latency 1); otherwise fifo_out_wr_en=0 next cycle.
REQ-008 The downstream FIFO guarantees one entry of slack, because full is sampled one cycle before the write lands.
REQ-009 Pixel counter width = $clog2(FRAME_PIXELS+1); increments per transfer; on the transfer at count FRAME_PIXELS-1, clear to 0, set last_grant=N, return to IDLE.
REQ-010 frame_done SHALL assert together with the write of the frame's last pixel, for exactly one cycle.
REQ-011 Stalls (source empty or output full) mid-frame SHALL hold state and count indefinitely; no timeout, no preemption.
REQ-012 FRAME_PIXELS=1 SHALL work: each grant transfers one pixel and returns to IDLE.
REQ-013 Minimum gap between frames is one IDLE cycle (no write in the cycle after frame_done).

Reset
REQ-014 On reset, outputs SHALL be: fifo_out_wr_en=0, fifo_out_din=0, fifo_out_src=0, frame_done=0, both rd_en=0; state=IDLE, count=0, last_grant=1 (source 0 wins the first tie).
REQ-015 Reset mid-frame SHALL abandon the partial frame with no further writes or frame_done; any recovery of partial-frame data is the caller's responsibility.

Structure
REQ-016 State encodings and the default FIFO_DWIDTH SHALL live in the shared grayscale package/include.
REQ-017 The pixel counter SHALL be one sub-module, frame_counter (inc, clear, terminal-count output); the arbitration logic SHALL stay in frame_arbiter.

Verification (bench FRAME_PIXELS=4)
REQ-018 Only FIFO 0 holds 4 pixels 0x102030.., output never full -> 4 writes with src=0 on consecutive cycles; frame_done pulses on the 4th write.
REQ-019 Both FIFOs hold 8 pixels after reset -> frame order src 0,1,0,1; never a mixed frame; one IDLE cycle between frames.
REQ-020 fifo_out_full held high for 3 cycles after pixel 2 of a frame -> no rd_en and no writes during the hold; the frame completes afterwards with count=4.
REQ-021 FIFO 1 goes empty after 2 pixels of a frame while FIFO 0 is full -> the arbiter waits in BURST1 with no FIFO 0 reads until FIFO 1 delivers pixels 3 and 4.
REQ-022 Reset asserted after 2 pixels of a frame -> all outputs 0 next cycle, no frame_done, and the next tie grants src 0.
